mcu_branch_resolve_queue: RTL

// - Update-side partner of the MCU 2-bit BHT predictor. Tracks in-flight predicted branches in program order.
// - Compares each prediction with the execute-stage outcome.
// - Drives the BHT training port (update_valid/update_pc/update_taken) and the fetch redirect on mispredict.
// - Sits between decode (alloc), execute (resolve) and the fetch/BHT.

---
 rtl/mcu_branch_resolve_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mcu_branch_resolve_queue.sv
// In-order queue of predicted branches: checks each prediction against execute, trains the BHT, redirects fetch.
// Optional perf counters are built only when MCU_BRQ_PERF_EN is defined.
module mcu_branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [PC_W-1:0] alloc_pc,
  input  logic            alloc_pred_taken,
  input  logic [PC_W-1:0] alloc_pred_target,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [PC_W-1:0] resolve_target,
  input  logic            flush_in,
  output logic            update_valid,
  output logic [PC_W-1:0] update_pc,
  output logic            update_taken,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            empty,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0] r_pc  [DEPTH];
  logic            r_pt  [DEPTH];
  logic [PC_W-1:0] r_tgt [DEPTH];

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;

  logic            r_upd_valid;
  logic [PC_W-1:0] r_upd_pc;
  logic            r_upd_taken;
  logic            r_redir_valid;
  logic [PC_W-1:0] r_redir_pc;

  logic            w_push;
  logic            w_resolve;
  logic            w_mispredict;
  logic            w_write;
  logic [PC_W-1:0] w_head_pc;

  assign alloc_ready  = (r_count != FULL);
  assign empty        = (r_count == '0);
  assign w_push       = alloc_valid && alloc_ready;
  assign w_resolve    = resolve_valid && !empty && !flush_in;
  assign w_head_pc    = r_pc[r_head];
  assign w_mispredict = (r_pt[r_head] != resolve_taken) ||
                        (resolve_taken && (r_tgt[r_head] != resolve_target));
  // A mispredict squashes the queue, so a same-cycle alloc is wrong-path and dropped.
  assign w_write      = w_push && !flush_in && !(w_resolve && w_mispredict);

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_pc[r_tail]  <= alloc_pc;
      r_pt[r_tail]  <= alloc_pred_taken;
      r_tgt[r_tail] <= alloc_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_taken   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_upd_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
      if (flush_in || (w_resolve && w_mispredict)) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_write)   r_tail <= r_tail + AW'(1);
        if (w_resolve) r_head <= r_head + AW'(1);
        r_count <= r_count + {{AW{1'b0}}, w_write} - {{AW{1'b0}}, w_resolve};
      end
      if (w_resolve) begin
        r_upd_valid   <= 1'b1;
        r_upd_pc      <= w_head_pc;
        r_upd_taken   <= resolve_taken;
        r_redir_valid <= w_mispredict;
        r_redir_pc    <= resolve_taken ? resolve_target : (w_head_pc + PC_W'(4));
      end
    end
  end

  assign update_valid   = r_upd_valid;
  assign update_pc      = r_upd_pc;
  assign update_taken   = r_upd_taken;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

`ifdef MCU_BRQ_PERF_EN
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else if (w_resolve) begin
      r_perf_br <= r_perf_br + 32'd1;
      if (w_mispredict) r_perf_mis <= r_perf_mis + 32'd1;
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
